// File: rtl/spr_hfilter_11bit.sv
// Horizontal [1 2 1]/4 sub-pixel filter with edge replication, per-pixel bypass and a
// sticky per-frame line-length check; data and syncs both leave 2 cycles after entry.
module spr_hfilter_11bit #(
    parameter int DW       = 11,
    parameter int H_ACTIVE = 1920,
    parameter int CW       = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_hs,
    input  logic          i_vs,
    input  logic [DW-1:0] i_pixel,
    input  logic          i_bypass,
    output logic          o_hs,
    output logic          o_vs,
    output logic [DW-1:0] o_pixel,
    output logic          o_len_err
);

    localparam logic [CW-1:0] H_LEN   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [DW+1:0] RND     = (DW+2)'(2);

    // Stage 1 holds x[k] and its left neighbour; stage 2 is the output register.
    logic          cur_vld_q, cur_vld_d;
    logic          cur_byp_q, cur_byp_d;
    logic [DW-1:0] cur_q,     cur_d;
    logic [DW-1:0] prev_q,    prev_d;
    logic          hs_q,      hs_d;
    logic          vs_q,      vs_d;
    logic          o_hs_q,    o_hs_d;
    logic          o_vs_q,    o_vs_d;
    logic [DW-1:0] o_pix_q,   o_pix_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic          vs_prev_q, vs_prev_d;
    logic          err_q,     err_d;

    logic          active;
    logic [DW-1:0] right;
    logic [DW+1:0] sum;
    logic          len_fail;
    logic          vs_rise;

    always_comb begin
        active    = i_hs & i_vs;
        // A new line (previous cycle not active) replicates x[0] as its own left neighbour.
        prev_d    = cur_vld_q ? cur_q : i_pixel;
        cur_d     = i_pixel;
        cur_byp_d = i_bypass;
        cur_vld_d = active;

        // Right neighbour is the next active pixel, else x[N-1] replicated.
        right = active ? i_pixel : cur_q;
        sum   = {2'b00, prev_q} + {1'b0, cur_q, 1'b0} + {2'b00, right} + RND;

        if (!cur_vld_q)
            o_pix_d = '0;
        else if (cur_byp_q)
            o_pix_d = cur_q;
        else
            o_pix_d = sum[DW+1:2];

        hs_d   = i_hs;
        vs_d   = i_vs;
        o_hs_d = hs_q;
        o_vs_d = vs_q;

        // Any inactive cycle ends the run; only an hs-terminated run inside the frame is checked.
        if (active)
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        else
            cnt_d = '0;
        len_fail  = !active && i_vs && (cnt_q != '0) && (cnt_q != H_LEN);

        vs_prev_d = i_vs;
        vs_rise   = i_vs & ~vs_prev_q;
        if (len_fail)
            err_d = 1'b1;
        else if (vs_rise)
            err_d = 1'b0;
        else
            err_d = err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_vld_q <= 1'b0;
            cur_byp_q <= 1'b0;
            cur_q     <= '0;
            prev_q    <= '0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            o_hs_q    <= 1'b0;
            o_vs_q    <= 1'b0;
            o_pix_q   <= '0;
            cnt_q     <= '0;
            vs_prev_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cur_vld_q <= cur_vld_d;
            cur_byp_q <= cur_byp_d;
            cur_q     <= cur_d;
            prev_q    <= prev_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            o_hs_q    <= o_hs_d;
            o_vs_q    <= o_vs_d;
            o_pix_q   <= o_pix_d;
            cnt_q     <= cnt_d;
            vs_prev_q <= vs_prev_d;
            err_q     <= err_d;
        end
    end

    assign o_hs      = o_hs_q;
    assign o_vs      = o_vs_q;
    assign o_pixel   = o_pix_q;
    assign o_len_err = err_q;

endmodule

// File: tb/tb_spr_hfilter_11bit.sv
// Bench for spr_hfilter_11bit with H_ACTIVE=4: vector table, hand sequences, and random
// traffic checked every cycle against an input-log based model of the filter rules.
module tb_spr_hfilter_11bit;

    localparam int DW   = 11;
    localparam int HA   = 4;
    localparam int MAXC = 16384;

    logic          clk = 1'b0;
    logic          rst_n, i_hs, i_vs, i_bypass;
    logic [DW-1:0] i_pixel;
    logic          o_hs, o_vs, o_len_err;
    logic [DW-1:0] o_pixel;

    spr_hfilter_11bit #(.DW(DW), .H_ACTIVE(HA), .CW(12)) dut (
        .clk(clk), .rst_n(rst_n), .i_hs(i_hs), .i_vs(i_vs), .i_pixel(i_pixel),
        .i_bypass(i_bypass), .o_hs(o_hs), .o_vs(o_vs), .o_pixel(o_pixel),
        .o_len_err(o_len_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit          l_rst [MAXC];
    bit          l_hs  [MAXC];
    bit          l_vs  [MAXC];
    bit          l_byp [MAXC];
    int          l_pix [MAXC];
    int          outq  [$];
    bit          err_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic bit act_at(input int m);
        if (m < 0) return 1'b0;
        return l_rst[m] && l_hs[m] && l_vs[m];
    endfunction

    // Reference: y[k] from neighbours on the same line, edges replicated.
    always @(negedge clk) begin : mon
        int n, c, m, len, l, r, y;
        bit rise, fail;
        logic [DW+3:0] got, exp;
        n = cyc;
        if (n >= 1 && n < MAXC) begin
            c    = n - 1;
            rise = l_vs[c] && (c == 0 || !l_vs[c-1] || !l_rst[c-1]);
            fail = 1'b0;
            if (l_rst[c] && !act_at(c) && act_at(c-1) && l_vs[c]) begin
                len = 0;
                for (int j = c - 1; act_at(j); j--) len++;
                fail = (len != HA);
            end
            if (!l_rst[c])  err_m = 1'b0;
            else if (fail)  err_m = 1'b1;
            else if (rise)  err_m = 1'b0;
        end
        if (n >= 2 && n < MAXC) begin
            m = n - 2;
            y = 0;
            if (l_rst[n-1] && act_at(m)) begin
                l = act_at(m-1) ? l_pix[m-1] : l_pix[m];
                r = act_at(m+1) ? l_pix[m+1] : l_pix[m];
                y = l_byp[m] ? l_pix[m] : (l + 2*l_pix[m] + r + 2) / 4;
            end
            exp = {l_rst[n-1] && l_rst[m] && l_hs[m], l_rst[n-1] && l_rst[m] && l_vs[m],
                   err_m, DW'(y)};
            got = {o_hs, o_vs, o_len_err, o_pixel};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL model cyc %0d: hs/vs/err/pix got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                         n, got[DW+3], got[DW+2], got[DW+1], got[DW-1:0],
                         exp[DW+3], exp[DW+2], exp[DW+1], exp[DW-1:0]);
            end
        end
        if (o_hs === 1'b1 && o_vs === 1'b1) outq.push_back(int'(o_pixel));
    end

    task automatic step(input bit r, input bit hs, input bit vs, input int pix, input bit byp);
        rst_n = r; i_hs = hs; i_vs = vs; i_pixel = DW'(pix); i_bypass = byp;
        if (cyc < MAXC) begin
            l_rst[cyc] = r; l_hs[cyc] = hs; l_vs[cyc] = vs; l_pix[cyc] = pix; l_byp[cyc] = byp;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic gap(input int k, input bit vs);
        for (int i = 0; i < k; i++) step(1'b1, 1'b0, vs, 0, 1'b0);
    endtask

    task automatic chk_outq(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        chk({name, " count"}, outq.size(), n);
        for (int i = 0; i < n && i < outq.size(); i++) chk(name, outq[i], e[i]);
    endtask

    typedef struct {
        int       n;
        int       pix [6];
        bit [5:0] byp;
        int       exp [6];
        bit       exp_err;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int   p [4];
        tbl[0] = '{4, '{100, 200, 300, 400, 0, 0}, 6'b000000, '{125, 200, 300, 375, 0, 0}, 1'b0};
        tbl[1] = '{1, '{1500, 0, 0, 0, 0, 0},     6'b000000, '{1500, 0, 0, 0, 0, 0},     1'b1};
        tbl[2] = '{4, '{0, 2047, 0, 2047, 0, 0},  6'b000000, '{512, 1024, 1024, 1535, 0, 0}, 1'b0};
        tbl[3] = '{4, '{10, 50, 90, 130, 0, 0},   6'b000010, '{20, 50, 90, 120, 0, 0},   1'b0};
        tbl[4] = '{5, '{7, 7, 7, 7, 7, 0},        6'b000000, '{7, 7, 7, 7, 7, 0},        1'b1};
        tbl[5] = '{3, '{0, 4, 8, 0, 0, 0},        6'b000000, '{1, 4, 7, 0, 0, 0},        1'b1};

        // Reset while the input claims to be active.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b1, 12'h7FF, 1'b0);
            chk("reset outputs", {o_hs, o_vs, o_len_err, o_pixel}, '0);
        end
        step(1'b1, 1'b1, 1'b1, 300, 1'b0);
        chk("first pixel not at +1", o_hs, 1'b0);
        step(1'b1, 1'b1, 1'b1, 300, 1'b0);
        chk("first pixel hs at +2", o_hs, 1'b1);
        chk("first pixel at +2", o_pixel, 300);
        step(1'b1, 1'b1, 1'b1, 300, 1'b0);
        step(1'b1, 1'b1, 1'b1, 300, 1'b0);
        gap(3, 1'b1);
        chk("len err after reset line", o_len_err, 1'b0);

        for (int t = 0; t < 6; t++) begin
            step(1'b1, 1'b0, 1'b0, 0, 1'b0);
            gap(1, 1'b1);
            outq.delete();
            for (int k = 0; k < tbl[t].n; k++) step(1'b1, 1'b1, 1'b1, tbl[t].pix[k], tbl[t].byp[k]);
            gap(3, 1'b1);
            chk($sformatf("vec%0d count", t), outq.size(), tbl[t].n);
            for (int k = 0; k < tbl[t].n && k < outq.size(); k++)
                chk($sformatf("vec%0d y%0d", t, k), outq[k], tbl[t].exp[k]);
            chk($sformatf("vec%0d len_err", t), o_len_err, tbl[t].exp_err);
        end

        // Lines separated by a single hs gap: no tap leakage, blanked in the gap.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        gap(1, 1'b1);
        outq.delete();
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, 1000, 1'b0);
        gap(1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 0, 1'b0);
        chk("gap blank hs", o_hs, 1'b0);
        chk("gap blank pix", o_pixel, 0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, 0, 1'b0);
        gap(3, 1'b1);
        chk("line2 count", outq.size(), 8);
        if (outq.size() == 8) begin
            chk("line1 tail", outq[3], 1000);
            chk("line2 left edge", outq[4], 0);
        end

        // Sticky length error: lines of 4, 3, 4, frame restart, then 5.
        p = '{1, 2, 3, 4};
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, p[k], 1'b0);
        gap(2, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b1, p[k], 1'b0);
        chk("err not before check", o_len_err, 1'b0);
        gap(1, 1'b1);
        chk("err rises", o_len_err, 1'b1);
        gap(2, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, p[k], 1'b0);
        gap(2, 1'b1);
        chk("err holds", o_len_err, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("err before rise", o_len_err, 1'b1);
        step(1'b1, 1'b0, 1'b1, 0, 1'b0);
        chk("err cleared after vs rise", o_len_err, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b1, 9, 1'b0);
        gap(3, 1'b1);
        chk("err on long line", o_len_err, 1'b1);

        // vs falls after two pixels: truncated line, right-replicated, unchecked.
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        gap(2, 1'b1);
        outq.delete();
        step(1'b1, 1'b1, 1'b1, 100, 1'b0);
        step(1'b1, 1'b1, 1'b1, 200, 1'b0);
        step(1'b1, 1'b1, 1'b0, 300, 1'b0);
        step(1'b1, 1'b1, 1'b0, 400, 1'b0);
        gap(3, 1'b1);
        chk_outq("truncated", 2, 125, 175, 0, 0);
        chk("truncated no err", o_len_err, 1'b0);

        // Reset mid-line, then a fresh line of exactly H_ACTIVE pixels.
        step(1'b1, 1'b1, 1'b1, 500, 1'b0);
        step(1'b1, 1'b1, 1'b1, 600, 1'b0);
        step(1'b0, 1'b1, 1'b1, 700, 1'b0);
        chk("mid reset outputs", {o_hs, o_vs, o_len_err, o_pixel}, '0);
        outq.delete();
        p = '{40, 80, 120, 160};
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1, p[k], 1'b0);
        gap(3, 1'b1);
        chk_outq("after reset", 4, 50, 80, 120, 150);
        chk("after reset no err", o_len_err, 1'b0);

        // Random traffic against the model.
        for (int ln = 0; ln < 150; ln++) begin
            int n, trunc;
            if ($urandom_range(0, 5) == 0) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
            if ($urandom_range(0, 39) == 0) step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
            n     = $urandom_range(1, 6);
            trunc = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, n)) : n + 1;
            for (int k = 0; k < n; k++) begin
                if (k == trunc) begin
                    step(1'b1, 1'b1, 1'b0, $urandom_range(0, 2047), 1'b0);
                    break;
                end
                step(1'b1, 1'b1, 1'b1, $urandom_range(0, 2047), ($urandom_range(0, 3) == 0));
            end
            gap($urandom_range(1, 3), 1'b1);
        end
        gap(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
